// File: rtl/ceespu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ceespu_irq_ctrl
// Purpose  : Interrupt entry sequencer for the ceespu pipeline. Latches
//            rising edges on the external request lines, masks them, picks
//            the lowest-index pending source, waits for a safe decode slot,
//            then pulses did_interrupt/take (fetch redirect to the vector),
//            captures the return PC and issues a one-cycle pipeline flush
//            followed by a short hold-off.
// Ports    :
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_irq[NUM_IRQ]        raw request lines (rising-edge sensitive)
//   I_mask_we/I_mask_data mask register write (1 = source enabled)
//   I_interrupts_enabled  global enable from decode
//   I_stall               pipeline stall seen by decode
//   I_imm_prefix          decode holds an IMM prefix
//   I_is_branch           decode holds a branch
//   I_PC[14]              PC of the instruction in decode
//   O_did_interrupt       to decode, disables further interrupts
//   O_take                fetch redirect strobe
//   O_vector[14]          redirect target, valid while O_take
//   O_flush               pipeline flush pulse
//   O_epc[14]             captured return address
//   O_cause[3]            index of the last taken source
//   O_pending[NUM_IRQ]    pending register
//   O_busy                sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module ceespu_irq_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [13:0] VECTOR_BASE = 14'h0004,
  parameter int          HOLD_CYCLES = 2
) (
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic               I_mask_we,
  input  logic [NUM_IRQ-1:0] I_mask_data,
  input  logic               I_interrupts_enabled,
  input  logic               I_stall,
  input  logic               I_imm_prefix,
  input  logic               I_is_branch,
  input  logic [13:0]        I_PC,
  output logic               O_did_interrupt,
  output logic               O_take,
  output logic [13:0]        O_vector,
  output logic               O_flush,
  output logic [13:0]        O_epc,
  output logic [2:0]         O_cause,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic               O_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] c_HOLD_INIT = 4'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [13:0]        vector_q, vector_d;
  logic [13:0]        epc_q, epc_d;
  logic [2:0]         cause_q, cause_d;

  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_req;
  logic [2:0]         w_win;
  logic               w_safe;
  logic               w_take;
  logic               w_clr_sel;

  assign w_rise = I_irq & ~irq_prev_q;
  assign w_req  = pending_q & mask_q;
  // An IMM prefix must stay glued to its consumer and a branch in decode
  // would lose its target, so neither is a legal interrupt point.
  assign w_safe = !I_stall && !I_imm_prefix && !I_is_branch;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_win = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_win = 3'(i);
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vector_d  = vector_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    w_take    = 1'b0;
    w_clr_sel = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((w_req != '0) && I_interrupts_enabled) begin
          state_d  = ST_ENTER;
          vector_d = VECTOR_BASE + {11'd0, w_win};
          cause_d  = w_win;
        end
      end
      ST_ENTER: begin
        // Selection is frozen in cause_q; a later mask change does not
        // cancel it, only a drop of the global enable does.
        if (!I_interrupts_enabled) begin
          state_d = ST_IDLE;
        end else if (w_safe) begin
          w_take    = 1'b1;
          epc_d     = I_PC + 14'd1;
          w_clr_sel = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_HOLD;
        cnt_d   = c_HOLD_INIT;
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear of the taken source first, then new edges OR in, so a set
  // arriving on the same edge as the clear is not lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_clr_sel && (cause_q == 3'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    pending_d = pending_d | w_rise;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      vector_q   <= 14'd0;
      epc_q      <= 14'd0;
      cause_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      irq_prev_q <= I_irq;
      vector_q   <= vector_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      if (I_mask_we) begin
        mask_q <= I_mask_data;
      end
    end
  end

  assign O_did_interrupt = w_take;
  assign O_take          = w_take;
  assign O_vector        = vector_q;
  // Flush is a decode of the registered FLUSH state: exactly one cycle and
  // never in the same cycle as did_interrupt.
  assign O_flush         = (state_q == ST_FLUSH);
  assign O_epc           = epc_q;
  assign O_cause         = cause_q;
  assign O_pending       = pending_q;
  assign O_busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ceespu_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ceespu_irq_ctrl
// Purpose  : Self-checking bench for ceespu_irq_ctrl. Each table row holds
//            the inputs for one clock cycle and the outputs expected during
//            that cycle; a few hand-written sequences cover latency and
//            reset in the middle of an entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ceespu_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_data;
  logic        en;
  logic        stall;
  logic        imm;
  logic        br;
  logic [13:0] pc;

  logic        did, take, flush, busy;
  logic [13:0] vector, epc;
  logic [2:0]  cause;
  logic [3:0]  pending;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ceespu_irq_ctrl #(
    .NUM_IRQ    (4),
    .VECTOR_BASE(14'h0004),
    .HOLD_CYCLES(2)
  ) dut (
    .I_clk               (clk),
    .I_rst               (rst),
    .I_irq               (irq),
    .I_mask_we           (mask_we),
    .I_mask_data         (mask_data),
    .I_interrupts_enabled(en),
    .I_stall             (stall),
    .I_imm_prefix        (imm),
    .I_is_branch         (br),
    .I_PC                (pc),
    .O_did_interrupt     (did),
    .O_take              (take),
    .O_vector            (vector),
    .O_flush             (flush),
    .O_epc               (epc),
    .O_cause             (cause),
    .O_pending           (pending),
    .O_busy              (busy)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic        we;
    logic [3:0]  md;
    logic        en;
    logic        st;
    logic        imm;
    logic        br;
    logic [13:0] pc;
    logic        tk;
    logic [13:0] vec;
    logic        fl;
    logic [13:0] epc;
    logic [2:0]  cause;
    logic [3:0]  pend;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic r, input logic [3:0] i, input logic w,
                            input logic [3:0] m, input logic e, input logic s,
                            input logic im, input logic b, input logic [13:0] p,
                            input logic tk, input logic [13:0] ve, input logic fl,
                            input logic [13:0] ep, input logic [2:0] ca,
                            input logic [3:0] pe, input logic bu);
    vec_t t;
    t = '{r, i, w, m, e, s, im, b, p, tk, ve, fl, ep, ca, pe, bu};
    tbl.push_back(t);
  endfunction

  // take and did_interrupt are both compared against the same expected bit.
  task automatic check(input string name, input logic tk, input logic [13:0] ve,
                       input logic fl, input logic [13:0] ep, input logic [2:0] ca,
                       input logic [3:0] pe, input logic bu);
    logic [38:0] got, exp;
    got = {take, did, vector, flush, epc, cause, pending, busy};
    exp = {tk, tk, ve, fl, ep, ca, pe, bu};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got take=%b did=%b vec=%h flush=%b epc=%h cause=%0d pend=%b busy=%b; want take=%b vec=%h flush=%b epc=%h cause=%0d pend=%b busy=%b",
               name, take, did, vector, flush, epc, cause, pending, busy,
               tk, ve, fl, ep, ca, pe, bu);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] i, input logic w,
                       input logic [3:0] m, input logic e, input logic s,
                       input logic im, input logic b, input logic [13:0] p);
    rst = r; irq = i; mask_we = w; mask_data = m;
    en = e; stall = s; imm = im; br = b; pc = p;
  endtask

  initial begin
    int n;
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000);

    //  rst irq      we md       en st im br pc        | tk vec       fl epc       ca pend     busy
    // Single source 0, mask 0001, PC 0x120.
    v(0, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 14'h0120,  0, 14'h0000, 0, 14'h0000, 0, 4'b0000, 0); // c0 reset state
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0000, 0, 14'h0000, 0, 4'b0000, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0000, 0, 14'h0000, 0, 4'b0001, 0);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  1, 14'h0004, 0, 14'h0000, 0, 4'b0001, 1); // take
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0004, 1, 14'h0121, 0, 4'b0000, 1); // flush
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0004, 0, 14'h0121, 0, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0004, 0, 14'h0121, 0, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0004, 0, 14'h0121, 0, 4'b0000, 0); // c7 idle
    // Sources 3 and 1 together, mask 1111: 1 first, 3 after the hold.
    v(0, 4'b0000, 1, 4'b1111, 1, 0, 0, 0, 14'h0120,  0, 14'h0004, 0, 14'h0121, 0, 4'b0000, 0);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0120,  0, 14'h0004, 0, 14'h0121, 0, 4'b0000, 0);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0004, 0, 14'h0121, 0, 4'b1010, 0);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  1, 14'h0005, 0, 14'h0121, 1, 4'b1010, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0005, 1, 14'h0201, 1, 4'b1000, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0005, 0, 14'h0201, 1, 4'b1000, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0005, 0, 14'h0201, 1, 4'b1000, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0005, 0, 14'h0201, 1, 4'b1000, 0);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  1, 14'h0007, 0, 14'h0201, 3, 4'b1000, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0007, 1, 14'h0201, 3, 4'b0000, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0007, 0, 14'h0201, 3, 4'b0000, 1);
    v(0, 4'b1010, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0007, 0, 14'h0201, 3, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0200,  0, 14'h0007, 0, 14'h0201, 3, 4'b0000, 0); // c20
    // IMM prefix for three cycles delays the take; EPC follows the consumer.
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0300,  0, 14'h0007, 0, 14'h0201, 3, 4'b0000, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 1, 0, 14'h0300,  0, 14'h0007, 0, 14'h0201, 3, 4'b0001, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 1, 0, 14'h0300,  0, 14'h0004, 0, 14'h0201, 0, 4'b0001, 1);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 1, 0, 14'h0300,  0, 14'h0004, 0, 14'h0201, 0, 4'b0001, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0301,  1, 14'h0004, 0, 14'h0201, 0, 4'b0001, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0301,  0, 14'h0004, 1, 14'h0302, 0, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0301,  0, 14'h0004, 0, 14'h0302, 0, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0301,  0, 14'h0004, 0, 14'h0302, 0, 4'b0000, 1);
    // Stall held five cycles in ENTER.
    v(0, 4'b0100, 0, 4'b0000, 1, 0, 0, 0, 14'h0400,  0, 14'h0004, 0, 14'h0302, 0, 4'b0000, 0); // c29
    v(0, 4'b0100, 0, 4'b0000, 1, 0, 0, 0, 14'h0400,  0, 14'h0004, 0, 14'h0302, 0, 4'b0100, 0);
    v(0, 4'b0100, 0, 4'b0000, 1, 1, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0302, 2, 4'b0100, 1);
    v(0, 4'b0100, 0, 4'b0000, 1, 1, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0302, 2, 4'b0100, 1);
    v(0, 4'b0100, 0, 4'b0000, 1, 1, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0302, 2, 4'b0100, 1);
    v(0, 4'b0100, 0, 4'b0000, 1, 1, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0302, 2, 4'b0100, 1);
    v(0, 4'b0100, 0, 4'b0000, 1, 1, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0302, 2, 4'b0100, 1);
    v(0, 4'b0100, 0, 4'b0000, 1, 0, 0, 0, 14'h0400,  1, 14'h0006, 0, 14'h0302, 2, 4'b0100, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0400,  0, 14'h0006, 1, 14'h0401, 2, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0401, 2, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h0400,  0, 14'h0006, 0, 14'h0401, 2, 4'b0000, 1);
    // Branch in decode delays entry.
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0500,  0, 14'h0006, 0, 14'h0401, 2, 4'b0000, 0); // c40
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 1, 14'h0500,  0, 14'h0006, 0, 14'h0401, 2, 4'b0001, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 1, 14'h0500,  0, 14'h0004, 0, 14'h0401, 0, 4'b0001, 1);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0500,  1, 14'h0004, 0, 14'h0401, 0, 4'b0001, 1);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0500,  0, 14'h0004, 1, 14'h0501, 0, 4'b0000, 1);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0500,  0, 14'h0004, 0, 14'h0501, 0, 4'b0000, 1);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0500,  0, 14'h0004, 0, 14'h0501, 0, 4'b0000, 1);
    // Enable drops in ENTER: abort, pending kept, then entry resumes.
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0004, 0, 14'h0501, 0, 4'b0000, 0); // c47
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0004, 0, 14'h0501, 0, 4'b0010, 0);
    v(0, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0501, 1, 4'b0010, 1);
    v(0, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0501, 1, 4'b0010, 0);
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0501, 1, 4'b0010, 0);
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  1, 14'h0005, 0, 14'h0501, 1, 4'b0010, 1);
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 1, 14'h0601, 1, 4'b0000, 1);
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0000, 1);
    v(0, 4'b0010, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0000, 1);
    // Mask 0: source pends but is never taken; unmasking releases it.
    v(0, 4'b0000, 1, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0000, 0); // c56
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0000, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0001, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0001, 0);
    v(0, 4'b0001, 1, 4'b1111, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0001, 0);
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h0600,  0, 14'h0005, 0, 14'h0601, 1, 4'b0001, 0);
    // EPC wraps at 0x3FFF; reset during FLUSH clears everything.
    v(0, 4'b0001, 0, 4'b0000, 1, 0, 0, 0, 14'h3FFF,  1, 14'h0004, 0, 14'h0601, 0, 4'b0001, 1); // c62
    v(1, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h3FFF,  0, 14'h0004, 1, 14'h0000, 0, 4'b0000, 1);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h3FFF,  0, 14'h0000, 0, 14'h0000, 0, 4'b0000, 0);
    v(0, 4'b0000, 0, 4'b0000, 1, 0, 0, 0, 14'h3FFF,  0, 14'h0000, 0, 14'h0000, 0, 4'b0000, 0);

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i].rst, tbl[i].irq, tbl[i].we, tbl[i].md, tbl[i].en,
            tbl[i].st, tbl[i].imm, tbl[i].br, tbl[i].pc);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].tk, tbl[i].vec, tbl[i].fl,
            tbl[i].epc, tbl[i].cause, tbl[i].pend, tbl[i].busy);
    end

    // Latency: take must appear two cycles after the cycle the edge arrives.
    @(posedge clk); #1;
    drive(1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0700);
    @(posedge clk); #1;
    drive(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0700);
    n = 10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (take === 1'b1) begin
        n = k;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL take_latency: got %0d cycles, want 2", n);
    end

    // Reset asserted in the take cycle: no flush may follow.
    rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0700);
    @(negedge clk);
    check("rst_in_enter_0", 1'b0, 14'h0000, 1'b0, 14'h0000, 3'd0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_enter_1", 1'b0, 14'h0000, 1'b0, 14'h0000, 3'd0, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
